pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; clears all state immediately on assertion.
REQ-003 SHALL have port addressRegisterRsId, input, [25:21]: rs of the instruction in ID.
REQ-004 SHALL have port addressRegisterRtId, input, [20:16]: rt of the instruction in ID.
REQ-005 SHALL have port addressRegisterRtEx, input, [20:16]: rt held in ID/EX.
REQ-006 SHALL have port memReadEx, input, 1: ID/EX memRead.
REQ-007 SHALL have port branchTakenEx, input, 1: branch resolved taken in EX.
REQ-008 SHALL have port jumpEx, input, 1: ID/EX jump.
REQ-009 SHALL have port memBusy, input, 1: data memory not ready; whole pipeline must freeze.
REQ-010 SHALL have port pcWrite, output, 1: PC update enable.
REQ-011 SHALL have port ifIdWrite, output, 1: IF/ID load enable.
REQ-012 SHALL have port ifIdFlush, output, 1: IF/ID clear to NOP.
REQ-013 SHALL have port idExFlush, output, 1: ID/EX control fields forced to 0 (bubble).
REQ-014 SHALL have port pipeHold, output, 1: ID/EX, EX/MEM, MEM/WB hold current contents.
REQ-015 SHALL have port stallCount, output, [15:0]: saturating count of load-use stall cycles.
REQ-016 SHALL have port flushCount, output, [15:0]: saturating count of control-flow flushes.
REQ-017 SHALL have port memTimeout, output, 1: sticky flag, memBusy held too long.

Function
REQ-018 SHALL implement FSM states RUN, MEM_WAIT, REDIRECT; reset state RUN.
REQ-019 SHALL compute loadUse = memReadEx & rtEx!=0 & (rtEx==rsId | rtEx==rtId).
REQ-020 SHALL prioritise, per cycle: memBusy > (branchTakenEx|jumpEx) > loadUse > none.
REQ-021 SHALL, when memBusy=1 in any state: pcWrite=0, ifIdWrite=0, pipeHold=1, flushes=0; next state MEM_WAIT.
REQ-022 SHALL in MEM_WAIT count consecutive busy cycles with an 8-bit counter; on reaching 255 set memTimeout (sticky until reset); counter clears when memBusy=0.
REQ-023 SHALL, when memBusy falls in MEM_WAIT, return to RUN and evaluate lower priorities that same cycle.
REQ-024 SHALL, on branchTakenEx|jumpEx (no memBusy): ifIdFlush=1, idExFlush=1, pcWrite=1, ifIdWrite=1; next state REDIRECT; flushCount+1.
REQ-025 SHALL in REDIRECT (one cycle) suppress loadUse stalling and flush detection (EX holds a bubble); return to RUN unless memBusy.
REQ-026 SHALL, on loadUse in RUN: pcWrite=0, ifIdWrite=0, idExFlush=1, pipeHold=0; stallCount+1; state stays RUN.
REQ-027 SHALL, otherwise: pcWrite=1, ifIdWrite=1, all flush/hold 0.
REQ-028 SHALL drive control outputs combinationally from state and inputs (zero latency); counters/flag registered.
REQ-029 SHALL saturate stallCount and flushCount at 16'hFFFF, never wrap.

Reset
REQ-030 SHALL on reset: state RUN, stallCount=0, flushCount=0, busy counter=0, memTimeout=0.
REQ-031 SHALL, while reset=1, drive pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExFlush=1, pipeHold=0.
REQ-032 SHALL, on reset mid-MEM_WAIT or mid-REDIRECT, abandon the operation with no pending effect after release.

Structure
REQ-033 SHALL take the state enum type, counter widths (16, 8) and timeout limit 255 from shared package pipeline_ctrl_pkg.
REQ-034 SHALL instantiate sub-module sat_counter (parameterised width, inc, clear) for stallCount, flushCount and busy counter.

Verification
REQ-035 SHALL test load-use: memReadEx=1, rtEx=5, rsId=5 -> one cycle pcWrite=0, idExFlush=1, stallCount 0->1.
REQ-036 SHALL test rtEx=0 with memReadEx=1, rsId=0 -> no stall, stallCount unchanged.
REQ-037 SHALL test branchTakenEx=1 with simultaneous loadUse -> ifIdFlush=1, idExFlush=1, pcWrite=1, flushCount+1, stallCount unchanged; next cycle REDIRECT.
REQ-038 SHALL test memBusy=1 for 3 cycles during branchTakenEx -> pipeHold=1, no flush, no count; flush taken on the 4th cycle.
REQ-039 SHALL test memBusy=1 for 255 cycles -> memTimeout=1, remaining 1 after memBusy=0 until reset.
REQ-040 SHALL test stallCount preloaded near 16'hFFFF with further stalls -> holds 16'hFFFF; reset asserted in MEM_WAIT -> immediate RUN, counts 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, counter widths, memory-busy timeout limit and the load-use test.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } hz_state_t;

    localparam int EVT_CNT_W  = 16;
    localparam int BUSY_CNT_W = 8;
    localparam logic [BUSY_CNT_W-1:0] TIMEOUT_LIMIT = 8'd255;

    // Register $zero never carries a real dependency, so it cannot cause a stall.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rt_ex,
        input logic [4:0] rs_id,
        input logic [4:0] rt_id
    );
        return mem_read && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: memory freeze, branch/jump redirect
// flushes and load-use stalls, with event counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [25:21] addressRegisterRsId,
    input  logic [20:16] addressRegisterRtId,
    input  logic [20:16] addressRegisterRtEx,
    input  logic         memReadEx,
    input  logic         branchTakenEx,
    input  logic         jumpEx,
    input  logic         memBusy,
    output logic         pcWrite,
    output logic         ifIdWrite,
    output logic         ifIdFlush,
    output logic         idExFlush,
    output logic         pipeHold,
    output logic [15:0]  stallCount,
    output logic [15:0]  flushCount,
    output logic         memTimeout
);

    hz_state_t state_reg;
    hz_state_t state_next;

    logic                  load_use;
    logic                  redirect;
    logic                  stall_inc;
    logic                  flush_inc;
    logic [BUSY_CNT_W-1:0] busy_count;
    logic                  mem_timeout_reg;

    assign load_use = load_use_hit(memReadEx, addressRegisterRtEx,
                                   addressRegisterRsId, addressRegisterRtId);
    assign redirect = branchTakenEx | jumpEx;

    always_comb begin
        pcWrite    = 1'b1;
        ifIdWrite  = 1'b1;
        ifIdFlush  = 1'b0;
        idExFlush  = 1'b0;
        pipeHold   = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_next = ST_RUN;

        if (reset) begin
            // Keep the front end squashed while reset is held.
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            ifIdFlush = 1'b1;
            idExFlush = 1'b1;
        end else if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            pipeHold   = 1'b1;
            state_next = ST_MEM_WAIT;
        end else if (state_reg != ST_REDIRECT) begin
            // RUN, or MEM_WAIT just released: both resolve hazards normally this cycle.
            if (redirect) begin
                ifIdFlush  = 1'b1;
                idExFlush  = 1'b1;
                flush_inc  = 1'b1;
                state_next = ST_REDIRECT;
            end else if (load_use) begin
                pcWrite   = 1'b0;
                ifIdWrite = 1'b0;
                idExFlush = 1'b1;
                stall_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    sat_counter #(.WIDTH(EVT_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stallCount)
    );

    sat_counter #(.WIDTH(EVT_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flushCount)
    );

    // Every busy cycle of a freeze episode counts, including the one that enters MEM_WAIT.
    sat_counter #(.WIDTH(BUSY_CNT_W)) u_busy_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (memBusy),
        .clear (~memBusy),
        .count (busy_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_timeout_reg <= 1'b0;
        end else if (memBusy && (busy_count >= TIMEOUT_LIMIT - 8'd1)) begin
            mem_timeout_reg <= 1'b1;
        end
    end

    assign memTimeout = mem_timeout_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl: hand-computed expectations for
// stalls, flushes, memory freeze, timeout, saturation and mid-operation reset.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic [4:0]  rt_ex;
    logic        mem_read_ex;
    logic        branch_ex;
    logic        jump_ex;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        pipe_hold;
    logic [15:0] stall_count;
    logic [15:0] flush_count;
    logic        mem_timeout;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipeline_hazard_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .addressRegisterRsId (rs_id),
        .addressRegisterRtId (rt_id),
        .addressRegisterRtEx (rt_ex),
        .memReadEx           (mem_read_ex),
        .branchTakenEx       (branch_ex),
        .jumpEx              (jump_ex),
        .memBusy             (mem_busy),
        .pcWrite             (pc_write),
        .ifIdWrite           (if_id_write),
        .ifIdFlush           (if_id_flush),
        .idExFlush           (id_ex_flush),
        .pipeHold            (pipe_hold),
        .stallCount          (stall_count),
        .flushCount          (flush_count),
        .memTimeout          (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-18s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs packed as {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeHold}.
    function automatic logic [4:0] ctl();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold};
    endfunction

    task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                         input logic [4:0] rti, input logic br, input logic jp, input logic mb);
        mem_read_ex = mr;
        rt_ex       = rte;
        rs_id       = rsi;
        rt_id       = rti;
        branch_ex   = br;
        jump_ex     = jp;
        mem_busy    = mb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_FLUSH = 5'b11110;
    localparam logic [4:0] C_HOLD  = 5'b00001;
    localparam logic [4:0] C_RST   = 5'b00110;

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_ctl", 32'(ctl()), 32'(C_RST));
        chk("rst_stall", 32'(stall_count), 32'h0);
        chk("rst_flush", 32'(flush_count), 32'h0);
        chk("rst_timeout", 32'(mem_timeout), 32'h0);
        reset = 1'b0;
        #1;
        chk("idle_ctl", 32'(ctl()), 32'(C_RUN));

        // Load-use via rs
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("lu_rs_ctl", 32'(ctl()), 32'(C_STALL));
        tick();
        chk("lu_rs_cnt", 32'(stall_count), 32'd1);
        drive(1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("no_memread_ctl", 32'(ctl()), 32'(C_RUN));
        tick();
        chk("no_memread_cnt", 32'(stall_count), 32'd1);

        // Load-use via rt
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rt_ctl", 32'(ctl()), 32'(C_STALL));
        tick();
        chk("lu_rt_cnt", 32'(stall_count), 32'd2);

        // rtEx = $zero never stalls
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("zero_reg_ctl", 32'(ctl()), 32'(C_RUN));
        tick();
        chk("zero_reg_cnt", 32'(stall_count), 32'd2);

        // Branch beats a simultaneous load-use
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("br_lu_ctl", 32'(ctl()), 32'(C_FLUSH));
        tick();
        chk("br_lu_flush", 32'(flush_count), 32'd1);
        chk("br_lu_stall", 32'(stall_count), 32'd2);
        // REDIRECT: same inputs, stall and flush both suppressed
        chk("redir_ctl", 32'(ctl()), 32'(C_RUN));
        tick();
        chk("redir_flush", 32'(flush_count), 32'd1);
        chk("redir_stall", 32'(stall_count), 32'd2);
        // Back in RUN: the load-use now takes effect
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("post_redir_ctl", 32'(ctl()), 32'(C_STALL));
        tick();
        chk("post_redir_stall", 32'(stall_count), 32'd3);

        // Jump
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        chk("jump_ctl", 32'(ctl()), 32'(C_FLUSH));
        tick();
        chk("jump_flush", 32'(flush_count), 32'd2);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // memBusy for 3 cycles during a taken branch, flush on the 4th
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
            chk("busy_br_ctl", 32'(ctl()), 32'(C_HOLD));
            tick();
            chk("busy_br_flush", 32'(flush_count), 32'd2);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        chk("busy_rel_ctl", 32'(ctl()), 32'(C_FLUSH));
        tick();
        chk("busy_rel_flush", 32'(flush_count), 32'd3);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Memory timeout after 255 consecutive busy cycles
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 254; i++) tick();
        chk("timeout_254", 32'(mem_timeout), 32'h0);
        tick();
        chk("timeout_255", 32'(mem_timeout), 32'h1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("timeout_rel_ctl", 32'(ctl()), 32'(C_RUN));
        repeat (3) tick();
        chk("timeout_sticky", 32'(mem_timeout), 32'h1);

        // Stall counter saturation: 3 -> 0xFFFE -> 0xFFFF, then held
        drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65531; i++) tick();
        chk("stall_fffe", 32'(stall_count), 32'hFFFE);
        tick();
        chk("stall_ffff", 32'(stall_count), 32'hFFFF);
        repeat (3) tick();
        chk("stall_sat", 32'(stall_count), 32'hFFFF);

        // Reset in the middle of MEM_WAIT
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mw_stall", 32'(stall_count), 32'h0);
        chk("rst_mw_flush", 32'(flush_count), 32'h0);
        chk("rst_mw_timeout", 32'(mem_timeout), 32'h0);
        chk("rst_mw_ctl", 32'(ctl()), 32'(C_RST));
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_mw_rel_ctl", 32'(ctl()), 32'(C_RUN));
        tick();
        chk("rst_mw_rel_cnt", 32'(stall_count), 32'h0);

        // Reset in the middle of REDIRECT: no leftover suppression after release
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rst_rd_flush1", 32'(flush_count), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_rd_flush0", 32'(flush_count), 32'h0);
        reset = 1'b0;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_rd_lu_ctl", 32'(ctl()), 32'(C_STALL));
        tick();
        chk("rst_rd_lu_cnt", 32'(stall_count), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
